// File: rtl/hash_arbiter_pkg.sv
// hash_arbiter_pkg
// Shared definitions for the two-client hash engine arbiter: the FSM state
// encoding and the default widths and timeout used by the interface and the top.
package hash_arbiter_pkg;

  localparam int DW_DEFAULT      = 1088;  // rate-block width in bits
  localparam int HW_DEFAULT      = 256;   // digest width in bits
  localparam int TIMEOUT_DEFAULT = 200;   // engine no-response limit, cycles

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/hash_arbiter_if.sv
// hash_arbiter_if
// Bundles the client-side request/grant signals and the engine-side block and
// digest handshake. The slave modport is the arbiter's view; the master modport
// is the view of whatever drives the clients and the engine.
//   req0/req1, in0/in1, more0/more1 : client requests and current blocks
//   gnt*, nxt*, done*, err*         : per-client status pulses / levels
//   hash_out                        : last completed digest
//   eng_in_valid, eng_in, eng_more  : block strobe to the engine
//   eng_hash_next, eng_out_valid,
//   eng_out                         : engine responses
interface hash_arbiter_if
  import hash_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int HW = HW_DEFAULT
);
  logic          req0, req1;
  logic [DW-1:0] in0, in1;
  logic          more0, more1;
  logic          gnt0, gnt1;
  logic          nxt0, nxt1;
  logic          done0, done1;
  logic          err0, err1;
  logic [HW-1:0] hash_out;
  logic          eng_in_valid;
  logic [DW-1:0] eng_in;
  logic          eng_more;
  logic          eng_hash_next;
  logic          eng_out_valid;
  logic [HW-1:0] eng_out;

  modport slave (
    input  req0, req1, in0, in1, more0, more1,
    input  eng_hash_next, eng_out_valid, eng_out,
    output gnt0, gnt1, nxt0, nxt1, done0, done1, err0, err1,
    output hash_out, eng_in_valid, eng_in, eng_more
  );

  modport master (
    output req0, req1, in0, in1, more0, more1,
    output eng_hash_next, eng_out_valid, eng_out,
    input  gnt0, gnt1, nxt0, nxt1, done0, done1, err0, err1,
    input  hash_out, eng_in_valid, eng_in, eng_more
  );
endinterface

// File: rtl/hash_rr_pick.sv
// hash_rr_pick
// Two-way round-robin select. With a single request that client wins; with
// both, the client that was not served last wins.
//   i_req0, i_req1 : candidate requests
//   i_last         : client served most recently
//   o_valid        : at least one request present
//   o_sel          : selected client index
module hash_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_sel
);
  assign o_valid = i_req0 | i_req1;
  assign o_sel   = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter
// Shares one hash engine between two clients. A granted client's blocks are
// forwarded one at a time; the engine asks for the next block or returns the
// digest, and a silent engine is abandoned after TIMEOUT cycles.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : hash_arbiter_if slave modport (client and engine signals)
// All outputs come straight from registers.
module hash_arbiter
  import hash_arbiter_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int HW      = HW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  hash_arbiter_if.slave  bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        r_state, w_state_next;
  logic          r_owner, w_owner_next;
  logic          r_last, w_last_next;
  logic [7:0]    r_timer, w_timer_next;
  logic [1:0]    r_gnt, w_gnt_next;
  logic [1:0]    r_nxt, w_nxt_next;
  logic [1:0]    r_done, w_done_next;
  logic [1:0]    r_err, w_err_next;
  logic [HW-1:0] r_hash, w_hash_next;
  logic          r_eng_in_valid, w_eng_in_valid_next;
  logic [DW-1:0] r_eng_in, w_eng_in_next;
  logic          r_eng_more, w_eng_more_next;

  logic w_req0, w_req1, w_pick_valid, w_pick_sel;

  // A client still sees its req high during its own done/err pulse cycle,
  // because it only drops req after observing the pulse. Mask that stale
  // request so the finished client is not granted again.
  assign w_req0 = bus.req0 & ~r_done[0] & ~r_err[0];
  assign w_req1 = bus.req1 & ~r_done[1] & ~r_err[1];

  hash_rr_pick u_pick (
    .i_req0  (w_req0),
    .i_req1  (w_req1),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_sel   (w_pick_sel)
  );

  always_comb begin
    w_state_next        = r_state;
    w_owner_next        = r_owner;
    w_last_next         = r_last;
    w_timer_next        = r_timer;
    w_gnt_next          = r_gnt;
    w_nxt_next          = 2'b00;
    w_done_next         = 2'b00;
    w_err_next          = 2'b00;
    w_hash_next         = r_hash;
    w_eng_in_valid_next = 1'b0;
    w_eng_in_next       = r_eng_in;
    w_eng_more_next     = r_eng_more;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_owner_next = w_pick_sel;
          w_gnt_next   = w_pick_sel ? 2'b10 : 2'b01;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Right after an nxt pulse the client has not yet presented its
        // next block; wait out the pulse cycle before sampling in/more.
        if (r_nxt == 2'b00) begin
          w_eng_in_valid_next = 1'b1;
          w_eng_in_next       = r_owner ? bus.in1 : bus.in0;
          w_eng_more_next     = r_owner ? bus.more1 : bus.more0;
          w_timer_next        = 8'd0;
          w_state_next        = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.eng_out_valid) begin
          w_hash_next  = bus.eng_out;
          w_state_next = ST_FINISH;
        end else if (bus.eng_hash_next) begin
          w_nxt_next[r_owner] = 1'b1;
          w_state_next        = ST_ISSUE;
        end else if (r_timer == TMO_LAST) begin
          w_err_next[r_owner] = 1'b1;
          w_gnt_next          = 2'b00;
          w_last_next         = r_owner;
          w_state_next        = ST_IDLE;
        end else if (r_timer != 8'hFF) begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      ST_FINISH: begin
        w_done_next[r_owner] = 1'b1;
        w_gnt_next           = 2'b00;
        w_last_next          = r_owner;
        w_state_next         = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_owner        <= 1'b0;
      r_last         <= 1'b1;   // client 0 wins the first tie
      r_timer        <= 8'd0;
      r_gnt          <= 2'b00;
      r_nxt          <= 2'b00;
      r_done         <= 2'b00;
      r_err          <= 2'b00;
      r_hash         <= '0;
      r_eng_in_valid <= 1'b0;
      r_eng_in       <= '0;
      r_eng_more     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_owner        <= w_owner_next;
      r_last         <= w_last_next;
      r_timer        <= w_timer_next;
      r_gnt          <= w_gnt_next;
      r_nxt          <= w_nxt_next;
      r_done         <= w_done_next;
      r_err          <= w_err_next;
      r_hash         <= w_hash_next;
      r_eng_in_valid <= w_eng_in_valid_next;
      r_eng_in       <= w_eng_in_next;
      r_eng_more     <= w_eng_more_next;
    end
  end

  assign bus.gnt0         = r_gnt[0];
  assign bus.gnt1         = r_gnt[1];
  assign bus.nxt0         = r_nxt[0];
  assign bus.nxt1         = r_nxt[1];
  assign bus.done0        = r_done[0];
  assign bus.done1        = r_done[1];
  assign bus.err0         = r_err[0];
  assign bus.err1         = r_err[1];
  assign bus.hash_out     = r_hash;
  assign bus.eng_in_valid = r_eng_in_valid;
  assign bus.eng_in       = r_eng_in;
  assign bus.eng_more     = r_eng_more;

endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 Parameter DW, default 1088: rate-block width in bits.
REQ-002 Parameter HW, default 256: digest width in bits.
REQ-003 Parameter TIMEOUT, default 200: engine no-response limit in cycles, 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req0/req1  input  1  client request, level, held until done or err.
REQ-007 in0/in1  input  DW  client current rate block.
REQ-008 more0/more1  input  1  client has further blocks after the current one.
REQ-009 gnt0/gnt1  output  1  client owns the engine.
REQ-010 nxt0/nxt1  output  1  one-cycle pulse: client presents next block on in/more next cycle.
REQ-011 done0/done1  output  1  one-cycle pulse: hash_out valid for that client.
REQ-012 err0/err1  output  1  one-cycle pulse: transaction aborted on timeout.
REQ-013 hash_out  output  HW  last digest, held until next completion.
REQ-014 eng_in_valid  output  1  one-cycle block strobe to engine.
REQ-015 eng_in  output  DW  block to engine, registered.
REQ-016 eng_more  output  1  more flag to engine, registered.
REQ-017 eng_hash_next  input  1  engine requests the next block.
REQ-018 eng_out_valid  input  1  engine digest valid.
REQ-019 eng_out  input  HW  engine digest.

Function
REQ-020 States IDLE, ISSUE, RUN, FINISH; all outputs registered.
REQ-021 IDLE: one request -> grant it; both -> grant client != last_served; none -> stay; next state ISSUE, gnt asserted the cycle after the request is sampled.
REQ-022 ISSUE: eng_in_valid=1 for exactly one cycle with eng_in/eng_more = owner's in/more; timer cleared; -> RUN.
REQ-023 RUN: timer (8-bit, saturating) increments each cycle without engine response.
REQ-024 RUN, eng_out_valid=1: hash_out <= eng_out; -> FINISH.
REQ-025 RUN, eng_hash_next=1 and eng_out_valid=0: pulse nxt of owner; -> ISSUE; client updates in/more the cycle after the pulse.
REQ-026 eng_out_valid and eng_hash_next in the same cycle: eng_out_valid wins, eng_hash_next ignored.
REQ-027 RUN, timer reaches TIMEOUT-1 with no response: pulse err of owner, drop gnt, set last_served=owner, -> IDLE; hash_out unchanged.
REQ-028 FINISH: pulse done of owner, drop gnt, set last_served=owner, -> IDLE.
REQ-029 Request withdrawn while granted: ignored; transaction runs to done/err.
REQ-030 Request from non-owner during a transaction: held pending, served on return to IDLE.
REQ-031 At most one gnt, one nxt, one done, one err high at any cycle.
REQ-032 Minimum latency: request sampled cycle N -> gnt at N+1, eng_in_valid at N+2.

Reset
REQ-033 On rst: state IDLE, all outputs 0, hash_out 0, timer 0, owner 0, last_served 1 (client 0 preferred first).
REQ-034 rst mid-transaction aborts immediately; no done/err pulse issued; the engine is reset by the same rst.

Structure
REQ-035 Shared package holds state encoding, DW/HW defaults, TIMEOUT default.
REQ-036 One sub-module natural: hash_rr_pick (2-way round-robin select from req0, req1, last_served).

Verification
REQ-037 req0 only, single block, engine eng_out_valid 30 cycles after strobe with eng_out=256'hA5..A5 -> gnt0 at N+1, eng_in_valid at N+2, done0 pulse, hash_out=A5..A5.
REQ-038 req0 and req1 same cycle after reset -> client 0 served first, then client 1; second done is done1.
REQ-039 Two-block message on client 1: eng_hash_next after block 1 -> nxt1 pulse, second eng_in_valid carries block 2 with eng_more=0, then done1.
REQ-040 Engine silent, TIMEOUT=200 -> err0 pulse 200 cycles after eng_in_valid, gnt0 low, hash_out unchanged.
REQ-041 eng_out_valid and eng_hash_next together -> done pulse, no nxt pulse.
REQ-042 rst asserted in RUN -> all outputs 0 asynchronously, no done/err; fresh req0 afterwards completes normally.
